// File: rtl/mem_access_initiator.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_initiator
// Purpose  : Requester-side master for a single-word memory port. Accepts one
//            load/store at a time, converts the byte address to a word index,
//            rejects misaligned / out-of-range addresses, drives the read or
//            write valid level, and returns a one-cycle response pulse.
//            A wait that sees no ack for TIMEOUT_CYCLES edges ends in error.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset          clock / synchronous active-high reset
//   req_valid/ready     upstream handshake (ready only while idle)
//   req_we              1 = store, 0 = load
//   req_addr/wdata      byte address / store data
//   resp_valid          one-cycle response pulse
//   resp_rdata/err      load data (0 on store or error) / error flag
//   mem_rd_*            read channel: word address, valid level, data, ack
//   mem_wr_*            write channel: word address, data, valid level, ack
// ============================================================================
module mem_access_initiator #(
  parameter int MEM_WORDS      = 64000,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_rd_addr,
  output logic        mem_rd_addr_valid,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_ack,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_data_valid,
  input  logic        mem_wr_ack
);

  localparam int              CNT_W      = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]     WORD_LIMIT = 32'(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt, next_cnt;

  logic              nxt_resp_valid;
  logic [31:0]       nxt_resp_rdata;
  logic              nxt_resp_err;
  logic [31:0]       nxt_rd_addr;
  logic              nxt_rd_valid;
  logic [31:0]       nxt_wr_addr;
  logic [31:0]       nxt_wr_data;
  logic              nxt_wr_valid;

  logic [31:0]       word_idx;
  logic              addr_bad;
  logic              accept;

  assign word_idx = {2'b00, req_addr[31:2]};
  assign addr_bad = (req_addr[1:0] != 2'b00) || (word_idx >= WORD_LIMIT);

  // Ready is withheld for the cycle an error pulse is out, so back-to-back
  // rejected requests can never produce resp_valid on consecutive cycles.
  assign req_ready = (state == IDLE) && !resp_valid;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      resp_valid        <= 1'b0;
      resp_rdata        <= 32'd0;
      resp_err          <= 1'b0;
      mem_rd_addr       <= 32'd0;
      mem_rd_addr_valid <= 1'b0;
      mem_wr_addr       <= 32'd0;
      mem_wr_data       <= 32'd0;
      mem_wr_data_valid <= 1'b0;
    end else begin
      state             <= next_state;
      cnt               <= next_cnt;
      resp_valid        <= nxt_resp_valid;
      resp_rdata        <= nxt_resp_rdata;
      resp_err          <= nxt_resp_err;
      mem_rd_addr       <= nxt_rd_addr;
      mem_rd_addr_valid <= nxt_rd_valid;
      mem_wr_addr       <= nxt_wr_addr;
      mem_wr_data       <= nxt_wr_data;
      mem_wr_data_valid <= nxt_wr_valid;
    end
  end

  always_comb begin
    next_state     = state;
    next_cnt       = cnt;
    nxt_resp_valid = 1'b0;
    nxt_resp_err   = 1'b0;
    nxt_resp_rdata = resp_rdata;
    nxt_rd_addr    = mem_rd_addr;
    nxt_rd_valid   = mem_rd_addr_valid;
    nxt_wr_addr    = mem_wr_addr;
    nxt_wr_data    = mem_wr_data;
    nxt_wr_valid   = mem_wr_data_valid;

    case (state)
      IDLE: begin
        if (accept) begin
          if (addr_bad) begin
            nxt_resp_valid = 1'b1;
            nxt_resp_err   = 1'b1;
            nxt_resp_rdata = 32'd0;
          end else if (req_we) begin
            nxt_wr_addr  = word_idx;
            nxt_wr_data  = req_wdata;
            nxt_wr_valid = 1'b1;
            next_cnt     = '0;
            next_state   = WR_WAIT;
          end else begin
            nxt_rd_addr  = word_idx;
            nxt_rd_valid = 1'b1;
            next_cnt     = '0;
            next_state   = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        // Ack is tested before the timeout so it wins on a shared edge.
        if (mem_rd_ack) begin
          nxt_resp_valid = 1'b1;
          nxt_resp_rdata = mem_rd_data;
          nxt_rd_valid   = 1'b0;
          next_state     = DRAIN;
        end else if (cnt == CNT_LAST) begin
          nxt_resp_valid = 1'b1;
          nxt_resp_err   = 1'b1;
          nxt_resp_rdata = 32'd0;
          nxt_rd_valid   = 1'b0;
          next_state     = DRAIN;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end

      WR_WAIT: begin
        if (mem_wr_ack) begin
          nxt_resp_valid = 1'b1;
          nxt_resp_rdata = 32'd0;
          nxt_wr_valid   = 1'b0;
          next_state     = DRAIN;
        end else if (cnt == CNT_LAST) begin
          nxt_resp_valid = 1'b1;
          nxt_resp_err   = 1'b1;
          nxt_resp_rdata = 32'd0;
          nxt_wr_valid   = 1'b0;
          next_state     = DRAIN;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end

      DRAIN: begin
        // Wait for both level acks to fall so a stale ack cannot complete
        // the next request.
        if (!mem_rd_ack && !mem_wr_ack) begin
          next_state = IDLE;
        end
      end

      default: next_state = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_initiator
// Purpose  : Self-checking bench for mem_access_initiator. A behavioural
//            memory responder with configurable ack latency sits on the port;
//            expected responses come from a word-array model and the rules
//            for alignment, range, latency and timeout.
// Revision : 1.0 - initial release
// Ports    : none (top-level bench)
// ============================================================================
module tb_mem_access_initiator;

  localparam int MEM_WORDS = 64000;
  localparam int TO        = 16;
  localparam int NEVER     = 100000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_addr_valid;
  logic [31:0] mem_rd_data;
  logic        mem_rd_ack;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_data_valid;
  logic        mem_wr_ack;

  always #5 clk = ~clk;

  mem_access_initiator #(
    .MEM_WORDS      (MEM_WORDS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_we            (req_we),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_rdata        (resp_rdata),
    .resp_err          (resp_err),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_addr_valid (mem_rd_addr_valid),
    .mem_rd_data       (mem_rd_data),
    .mem_rd_ack        (mem_rd_ack),
    .mem_wr_addr       (mem_wr_addr),
    .mem_wr_data       (mem_wr_data),
    .mem_wr_data_valid (mem_wr_data_valid),
    .mem_wr_ack        (mem_wr_ack)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  // ---------------- behavioural memory responder ----------------
  logic [31:0] resp_mem [0:MEM_WORDS-1];
  logic        mem_init;
  int          resp_lat;
  int          rcnt;
  logic        rd_ack_r, wr_ack_r, stray_ack;
  logic [31:0] rd_data_r;

  assign mem_rd_ack  = rd_ack_r | stray_ack;
  assign mem_wr_ack  = wr_ack_r;
  assign mem_rd_data = rd_data_r;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_WORDS; i++) resp_mem[i] <= init_word(i);
      resp_mem[4] <= 32'hDEAD_BEEF;
    end else if (mem_wr_data_valid && rcnt >= resp_lat && !wr_ack_r && !reset
                 && mem_wr_addr < MEM_WORDS) begin
      resp_mem[mem_wr_addr[15:0]] <= mem_wr_data;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      rd_ack_r  <= 1'b0;
      wr_ack_r  <= 1'b0;
      rcnt      <= 0;
      rd_data_r <= 32'd0;
    end else if (mem_rd_addr_valid) begin
      if (rcnt >= resp_lat && !rd_ack_r) begin
        rd_ack_r  <= 1'b1;
        rd_data_r <= (mem_rd_addr < MEM_WORDS) ? resp_mem[mem_rd_addr[15:0]] : 32'hBAD0_BAD0;
      end
      rcnt <= rcnt + 1;
    end else if (mem_wr_data_valid) begin
      if (rcnt >= resp_lat && !wr_ack_r) wr_ack_r <= 1'b1;
      rcnt <= rcnt + 1;
    end else begin
      rd_ack_r <= 1'b0;
      wr_ack_r <= 1'b0;
      rcnt     <= 0;
    end
  end

  // The two request levels must never be high together.
  always @(negedge clk) begin
    if (reset === 1'b0) check("valid_exclusive", 32'(mem_rd_addr_valid & mem_wr_data_valid), 32'd0);
  end

  // ---------------- reference model ----------------
  logic [31:0] model_mem [0:MEM_WORDS-1];

  // Issue one request and check everything the model predicts about it.
  // Expected completion: the responder raises ack lat+1 edges after accept,
  // the DUT sees it one edge later; without ack by edge TO it times out.
  task automatic do_req(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int lat);
    int          k;
    logic [31:0] widx;
    logic        is_bad;
    logic        exp_err;
    int          exp_edges;
    logic [31:0] exp_rd;
    widx   = addr >> 2;
    is_bad = (addr % 4 != 0) || (widx >= MEM_WORDS);
    k = 0;
    while (!req_ready && k < 40) begin @(negedge clk); k++; end
    check("ready_before_req", 32'(req_ready), 32'd1);
    resp_lat  = lat;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (is_bad) begin
      check("bad_resp_valid", 32'(resp_valid), 32'd1);
      check("bad_resp_err",   32'(resp_err),   32'd1);
      check("bad_resp_rdata", resp_rdata,      32'd0);
      check("bad_no_mem",     32'({mem_rd_addr_valid, mem_wr_data_valid}), 32'd0);
      @(posedge clk); #1;
      check("bad_pulse_once", 32'(resp_valid), 32'd0);
      check("bad_no_mem_2",   32'({mem_rd_addr_valid, mem_wr_data_valid}), 32'd0);
    end else begin
      if (we) begin
        check("wr_valid", 32'(mem_wr_data_valid), 32'd1);
        check("wr_addr",  mem_wr_addr, widx);
        check("wr_data",  mem_wr_data, wdata);
        check("rd_valid_off", 32'(mem_rd_addr_valid), 32'd0);
      end else begin
        check("rd_valid", 32'(mem_rd_addr_valid), 32'd1);
        check("rd_addr",  mem_rd_addr, widx);
        check("wr_valid_off", 32'(mem_wr_data_valid), 32'd0);
      end
      check("busy_not_ready", 32'(req_ready), 32'd0);
      exp_err   = (lat > TO - 2);
      exp_edges = exp_err ? TO : lat + 2;
      exp_rd    = (we || exp_err) ? 32'd0 : model_mem[widx[15:0]];
      if (we && !exp_err) model_mem[widx[15:0]] = wdata;
      k = 0;
      do begin
        @(posedge clk); #1;
        k++;
      end while (!resp_valid && k < TO + 8);
      check("resp_seen",    32'(resp_valid), 32'd1);
      check("resp_latency", 32'(k), 32'(exp_edges));
      check("resp_err",     32'(resp_err), 32'(exp_err));
      check("resp_rdata",   resp_rdata, exp_rd);
      check("valid_dropped", 32'({mem_rd_addr_valid, mem_wr_data_valid}), 32'd0);
      @(posedge clk); #1;
      check("resp_pulse_once", 32'(resp_valid), 32'd0);
      if (!exp_err) begin
        check("drain_not_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
      end
      check("back_to_idle", 32'(req_ready), 32'd1);
    end
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] addr;
    int          sel, ls, lat;

    reset     = 1'b1;
    mem_init  = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    resp_lat  = 0;
    stray_ack = 1'b0;
    for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = init_word(i);
    model_mem[4] = 32'hDEAD_BEEF;

    @(posedge clk); #1;
    mem_init = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err",   32'(resp_err),   32'd0);
    check("rst_resp_rdata", resp_rdata,      32'd0);
    check("rst_rd_valid",   32'(mem_rd_addr_valid), 32'd0);
    check("rst_wr_valid",   32'(mem_wr_data_valid), 32'd0);
    check("rst_rd_addr",    mem_rd_addr, 32'd0);
    check("rst_wr_addr",    mem_wr_addr, 32'd0);
    check("rst_wr_data",    mem_wr_data, 32'd0);
    check("rst_ready",      32'(req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases.
    do_req(1'b0, 32'h0000_0010, 32'd0, 0);            // word 4 = DEADBEEF
    do_req(1'b1, 32'h0000_0020, 32'h1234_5678, 0);    // store word 8
    do_req(1'b0, 32'h0000_0020, 32'd0, 0);            // read it back
    do_req(1'b0, 32'h0000_0013, 32'd0, 0);            // misaligned
    do_req(1'b0, 32'h0003_E800, 32'd0, 0);            // word 64000: range
    do_req(1'b1, 32'h0003_E800, 32'h5555_AAAA, 0);    // range store: no write
    do_req(1'b0, 32'h0003_E7FC, 32'd0, 1);            // word 63999: last valid
    do_req(1'b0, 32'h0000_0040, 32'd0, TO - 2);       // ack on the timeout edge
    do_req(1'b1, 32'h0000_0044, 32'hCAFE_F00D, TO - 2);
    do_req(1'b0, 32'h0000_0044, 32'd0, 3);
    do_req(1'b0, 32'h0000_0048, 32'd0, NEVER);        // read timeout
    do_req(1'b1, 32'h0000_004C, 32'h0BAD_0BAD, NEVER);// write timeout
    do_req(1'b0, 32'h0000_004C, 32'd0, 0);            // timed-out store left no trace

    // Stray ack while idle must not produce a response.
    stray_ack = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("stray_no_resp",  32'(resp_valid), 32'd0);
      check("stray_no_valid", 32'({mem_rd_addr_valid, mem_wr_data_valid}), 32'd0);
    end
    @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);

    // Reset while a load waits for ack.
    resp_lat  = NEVER;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0000_0018;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("pre_rst_rd_valid", 32'(mem_rd_addr_valid), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_rd_valid",   32'(mem_rd_addr_valid), 32'd0);
    check("midrst_rd_addr",    mem_rd_addr, 32'd0);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_ready",      32'(req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("postrst_no_resp", 32'(resp_valid), 32'd0);
    end
    @(negedge clk);
    do_req(1'b0, 32'h0000_0018, 32'd0, 0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       addr = ($urandom_range(0, 63) << 2) | $urandom_range(1, 3);
        1:       addr = $urandom_range(64000, 64100) << 2;
        2:       addr = 32'(63999) << 2;
        default: addr = $urandom_range(0, 15) << 2;
      endcase
      ls  = int'($urandom_range(0, 7));
      lat = (ls < 5) ? ls : (ls == 5) ? TO - 2 : (ls == 6) ? TO - 3 : NEVER;
      do_req(1'($urandom_range(0, 1)), addr, $urandom, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
